// File: rtl/elbeth_branch_predictor_unit_pkg.sv
// Shared encodings and counter helpers for the ELBETH branch predictor unit.
// Operation codes, BHT reset values and the sequential PC increment live here.
package elbeth_branch_predictor_unit_pkg;

    typedef logic [1:0] bht_t;
    typedef logic [2:0] op_t;

    localparam op_t OP_JAL  = 3'd0;
    localparam op_t OP_JALR = 3'd1;
    localparam op_t OP_BEQ  = 3'd2;
    localparam op_t OP_BNE  = 3'd3;
    localparam op_t OP_BLT  = 3'd4;
    localparam op_t OP_BLTU = 3'd5;
    localparam op_t OP_BGE  = 3'd6;
    localparam op_t OP_BGEU = 3'd7;

    localparam bht_t BHT_SNT = 2'b00;
    localparam bht_t BHT_WNT = 2'b01;
    localparam bht_t BHT_WT  = 2'b10;
    localparam bht_t BHT_ST  = 2'b11;

    localparam int unsigned PC_INC = 4;

    function automatic bht_t sat_inc(input bht_t c);
        return (c == BHT_ST) ? BHT_ST : c + 2'd1;
    endfunction

    function automatic bht_t sat_dec(input bht_t c);
        return (c == BHT_SNT) ? BHT_SNT : c - 2'd1;
    endfunction

endpackage

// File: rtl/elbeth_branch_predictor_unit_if.sv
// Fetch-lookup and ID-resolve bundle of the branch predictor unit.
interface elbeth_branch_predictor_unit_if #(parameter int XLEN = 32);
    logic            if_pred_taken;
    logic [XLEN-1:0] if_pc;
    logic [XLEN-1:0] if_pred_target;
    logic            id_valid;
    logic            id_stall;
    logic [2:0]      id_operation;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_offset;
    logic [XLEN-1:0] id_data_rs1;
    logic [XLEN-1:0] id_data_rs2;
    logic            id_pred_taken;
    logic [XLEN-1:0] id_pred_target;
    logic            branch_taken;
    logic [XLEN-1:0] pc_branch;
    logic            mispredict;
    logic [31:0]     perf_branches;
    logic [31:0]     perf_mispredicts;

    modport master (
        output if_pc, id_valid, id_stall, id_operation, id_pc, id_offset,
               id_data_rs1, id_data_rs2, id_pred_taken, id_pred_target,
        input  if_pred_taken, if_pred_target, branch_taken, pc_branch,
               mispredict, perf_branches, perf_mispredicts
    );

    modport slave (
        input  if_pc, id_valid, id_stall, id_operation, id_pc, id_offset,
               id_data_rs1, id_data_rs2, id_pred_taken, id_pred_target,
        output if_pred_taken, if_pred_target, branch_taken, pc_branch,
               mispredict, perf_branches, perf_mispredicts
    );
endinterface

// File: rtl/elbeth_branch_predictor_unit_compare.sv
// Combinational branch resolver: operation and operands to taken flag and next PC.
module elbeth_branch_compare
    import elbeth_branch_predictor_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_valid,
    input  logic [2:0]      i_operation,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_offset,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    output logic            o_taken,
    output logic [XLEN-1:0] o_target
);
    logic            w_eq;
    logic            w_lt_s;
    logic            w_lt_u;
    logic            w_cond;
    logic [XLEN-1:0] w_rel;
    logic [XLEN-1:0] w_jalr;
    logic [XLEN-1:0] w_seq;

    assign w_eq   = (i_rs1 == i_rs2);
    assign w_lt_s = ($signed(i_rs1) < $signed(i_rs2));
    assign w_lt_u = (i_rs1 < i_rs2);
    assign w_rel  = i_pc + i_offset;
    assign w_jalr = (i_rs1 + i_offset) & {{(XLEN-1){1'b1}}, 1'b0};
    assign w_seq  = i_pc + XLEN'(PC_INC);

    // Branch condition per operation
    always_comb begin
        w_cond = 1'b0;
        case (i_operation)
            OP_JAL, OP_JALR: w_cond = 1'b1;
            OP_BEQ:          w_cond = w_eq;
            OP_BNE:          w_cond = ~w_eq;
            OP_BLT:          w_cond = w_lt_s;
            OP_BLTU:         w_cond = w_lt_u;
            OP_BGE:          w_cond = ~w_lt_s;
            OP_BGEU:         w_cond = ~w_lt_u;
            default:         w_cond = 1'b0;
        endcase
    end

    assign o_taken = i_valid & w_cond;

    // Next-PC selection
    always_comb begin
        if (!o_taken) begin
            o_target = w_seq;
        end else if (i_operation == OP_JALR) begin
            o_target = w_jalr;
        end else begin
            o_target = w_rel;
        end
    end
endmodule

// File: rtl/elbeth_branch_predictor_unit.sv
// Branch resolution plus direct-mapped BTB / 2-bit BHT predictor for ELBETH.
// Define ELBETH_BRANCH_PERF_EN to build the branch / mispredict event counters.
module elbeth_branch_predictor_unit
    import elbeth_branch_predictor_unit_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ENTRIES  = 64,
    parameter int IDX_BITS = $clog2(ENTRIES)
) (
    input  logic clk,
    input  logic rst_n,
    elbeth_branch_predictor_unit_if.slave bus
);
    localparam int TAG_BITS = XLEN - IDX_BITS - 2;

    logic [ENTRIES-1:0]  r_valid;
    logic [TAG_BITS-1:0] r_tag    [ENTRIES];
    logic [XLEN-1:0]     r_target [ENTRIES];
    bht_t                r_bht    [ENTRIES];

    logic [IDX_BITS-1:0] w_if_idx;
    logic [TAG_BITS-1:0] w_if_tag;
    logic                w_if_hit;
    logic [IDX_BITS-1:0] w_id_idx;
    logic [TAG_BITS-1:0] w_id_tag;
    logic                w_id_hit;
    logic                w_taken;
    logic [XLEN-1:0]     w_target;
    logic                w_mispredict;
    logic                w_upd;
    logic                w_is_jump;
    bht_t                w_bht_next;
    logic                w_unused_bits;

    assign w_unused_bits = ^bus.if_pc[1:0];

    assign w_if_idx = bus.if_pc[IDX_BITS+1:2];
    assign w_if_tag = bus.if_pc[XLEN-1:IDX_BITS+2];
    assign w_if_hit = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);

    assign bus.if_pred_taken  = w_if_hit & r_bht[w_if_idx][1];
    assign bus.if_pred_target = bus.if_pred_taken ? r_target[w_if_idx] : '0;

    elbeth_branch_compare #(.XLEN(XLEN)) u_compare (
        .i_valid     (bus.id_valid),
        .i_operation (bus.id_operation),
        .i_pc        (bus.id_pc),
        .i_offset    (bus.id_offset),
        .i_rs1       (bus.id_data_rs1),
        .i_rs2       (bus.id_data_rs2),
        .o_taken     (w_taken),
        .o_target    (w_target)
    );

    assign bus.branch_taken = w_taken;
    assign bus.pc_branch    = w_target;

    assign w_mispredict = bus.id_valid &
                          ((w_taken != bus.id_pred_taken) ||
                           (w_taken && (w_target != bus.id_pred_target)));
    assign bus.mispredict = w_mispredict;

    assign w_upd     = bus.id_valid & ~bus.id_stall;
    assign w_is_jump = (bus.id_operation == OP_JAL) || (bus.id_operation == OP_JALR);
    assign w_id_idx  = bus.id_pc[IDX_BITS+1:2];
    assign w_id_tag  = bus.id_pc[XLEN-1:IDX_BITS+2];
    assign w_id_hit  = r_valid[w_id_idx] && (r_tag[w_id_idx] == w_id_tag);

    // Next counter value; a taken miss allocates a fresh entry at weakly-taken
    always_comb begin
        w_bht_next = r_bht[w_id_idx];
        if (w_is_jump) begin
            w_bht_next = BHT_ST;
        end else if (w_taken) begin
            if (w_id_hit) begin
                w_bht_next = sat_inc(r_bht[w_id_idx]);
            end else begin
                w_bht_next = BHT_WT;
            end
        end else begin
            w_bht_next = sat_dec(r_bht[w_id_idx]);
        end
    end

    // BTB/BHT table write on each unstalled resolve
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_bht[i]    <= BHT_WNT;
            end
        end else if (w_upd) begin
            if (w_taken) begin
                r_valid[w_id_idx]  <= 1'b1;
                r_tag[w_id_idx]    <= w_id_tag;
                r_target[w_id_idx] <= w_target;
            end
            r_bht[w_id_idx] <= w_bht_next;
        end
    end

`ifdef ELBETH_BRANCH_PERF_EN
    logic [31:0] r_perf_branches;
    logic [31:0] r_perf_mispredicts;

    // Event counters, free-running with natural wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_branches    <= 32'd0;
            r_perf_mispredicts <= 32'd0;
        end else if (w_upd) begin
            r_perf_branches <= r_perf_branches + 32'd1;
            if (w_mispredict) begin
                r_perf_mispredicts <= r_perf_mispredicts + 32'd1;
            end
        end
    end

    assign bus.perf_branches    = r_perf_branches;
    assign bus.perf_mispredicts = r_perf_mispredicts;
`else
    assign bus.perf_branches    = 32'd0;
    assign bus.perf_mispredicts = 32'd0;
`endif
endmodule

// File: tb/tb_elbeth_branch_predictor_unit.sv
// Self-checking bench: directed spec scenarios plus randomized resolves against a table model.
module tb_elbeth_branch_predictor_unit;
    localparam int E = 64;

    localparam logic [2:0] JAL = 3'd0, JALR = 3'd1, BEQ = 3'd2, BNE = 3'd3,
                           BLT = 3'd4, BLTU = 3'd5, BGE = 3'd6, BGEU = 3'd7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    elbeth_branch_predictor_unit_if #(.XLEN(32)) bus ();

    elbeth_branch_predictor_unit #(.XLEN(32), .ENTRIES(E)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference tables: whole-PC tags and integer saturating counters
    bit          m_valid [E];
    longint      m_tagpc [E];
    int          m_ctr   [E];
    logic [31:0] m_tgt   [E];
    int          m_br, m_mp;

    // Values of the resolve currently driven
    logic [2:0]  s_op;
    logic [31:0] s_pc, s_tgt;
    logic        s_tk, s_v, s_st, s_mp;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((longint'(pc) / 4) % E);
    endfunction

    function automatic longint tag_of(input logic [31:0] pc);
        return longint'(pc) / (4 * E);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < E; i++) begin
            m_valid[i] = 1'b0; m_tagpc[i] = 0; m_ctr[i] = 1; m_tgt[i] = 32'd0;
        end
        m_br = 0; m_mp = 0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] pc, input logic [31:0] off,
                         input logic [31:0] rs1, input logic [31:0] rs2, input logic pt,
                         input logic [31:0] ptg, input logic v, input logic st,
                         input logic [31:0] lpc, input string tag);
        bit          cond;
        int          li;
        logic        l_tk;
        logic [31:0] l_tg;
        bus.if_pc = lpc; bus.id_operation = op; bus.id_pc = pc; bus.id_offset = off;
        bus.id_data_rs1 = rs1; bus.id_data_rs2 = rs2; bus.id_pred_taken = pt;
        bus.id_pred_target = ptg; bus.id_valid = v; bus.id_stall = st;
        #1;
        case (op)
            JAL, JALR: cond = 1'b1;
            BEQ:       cond = (rs1 == rs2);
            BNE:       cond = (rs1 != rs2);
            BLT:       cond = (int'(rs1) < int'(rs2));
            BLTU:      cond = (longint'(rs1) < longint'(rs2));
            BGE:       cond = !(int'(rs1) < int'(rs2));
            default:   cond = !(longint'(rs1) < longint'(rs2));
        endcase
        s_op = op; s_pc = pc; s_v = v; s_st = st;
        s_tk = v && cond;
        if (!s_tk)            s_tgt = pc + 32'd4;
        else if (op == JALR)  s_tgt = ((rs1 + off) >> 1) << 1;
        else                  s_tgt = pc + off;
        s_mp = v && ((s_tk != pt) || (s_tk && s_tgt != ptg));
        li   = idx_of(lpc);
        l_tk = m_valid[li] && (m_tagpc[li] == tag_of(lpc)) && (m_ctr[li] >= 2);
        l_tg = l_tk ? m_tgt[li] : 32'd0;
        chk({tag, ".taken"},   64'(bus.branch_taken),   64'(s_tk));
        chk({tag, ".pc"},      64'(bus.pc_branch),      64'(s_tgt));
        chk({tag, ".misp"},    64'(bus.mispredict),     64'(s_mp));
        chk({tag, ".pred_tk"}, 64'(bus.if_pred_taken),  64'(l_tk));
        chk({tag, ".pred_tg"}, 64'(bus.if_pred_target), 64'(l_tg));
    endtask

    task automatic commit(input string tag);
        int  i;
        bit  hit;
        @(posedge clk);
        if (s_v && !s_st) begin
            i   = idx_of(s_pc);
            hit = m_valid[i] && (m_tagpc[i] == tag_of(s_pc));
            if (s_tk) begin
                if (s_op == JAL || s_op == JALR) m_ctr[i] = 3;
                else if (hit)                     m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
                else                              m_ctr[i] = 2;
                m_valid[i] = 1'b1; m_tagpc[i] = tag_of(s_pc); m_tgt[i] = s_tgt;
            end else begin
                m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
            end
            m_br++;
            if (s_mp) m_mp++;
        end
        @(negedge clk);
`ifdef ELBETH_BRANCH_PERF_EN
        chk({tag, ".perf_br"}, 64'(bus.perf_branches),    64'(m_br));
        chk({tag, ".perf_mp"}, 64'(bus.perf_mispredicts), 64'(m_mp));
`else
        chk({tag, ".perf_br"}, 64'(bus.perf_branches),    64'd0);
        chk({tag, ".perf_mp"}, 64'(bus.perf_mispredicts), 64'd0);
`endif
    endtask

    function automatic logic [31:0] pool_pc();
        return 32'h1000 + (32'($urandom_range(0, 7)) << 8) + (32'($urandom_range(0, 3)) << 2);
    endfunction

    function automatic logic [31:0] pick_rs();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'hFFFF_FFFF;
            default: return 32'($urandom_range(0, 3));
        endcase
    endfunction

    initial begin
        int          pexp_br, pexp_mp;
        logic [2:0]  op;
        logic [31:0] pc, lpc, ptg;
        logic        pt;
        int          li;

        model_reset();
        drive(BEQ, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, "rst");
        repeat (2) @(negedge clk);
        chk("rst.pred_tk", 64'(bus.if_pred_taken), 64'd0);
        chk("rst.misp",    64'(bus.mispredict),    64'd0);
        chk("rst.pc",      64'(bus.pc_branch),     64'd4);
        rst_n = 1'b1;
        @(negedge clk);

        // Cold lookup and first BEQ resolve
        drive(BEQ, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0, 32'h0, 1'b1, 1'b0, 32'h100, "beq1");
        chk("beq1.tgt", 64'(bus.pc_branch), 64'h120);
        chk("beq1.mp",  64'(bus.mispredict), 64'd1);
        chk("beq1.lk",  64'(bus.if_pred_taken), 64'd0);
        commit("beq1");
        repeat (2) begin
            drive(BEQ, 32'h100, 32'h20, 32'd5, 32'd5, 1'b1, 32'h120, 1'b1, 1'b0, 32'h100, "beq2");
            commit("beq2");
        end
        drive(BEQ, 32'h100, 32'h20, 32'd5, 32'd5, 1'b1, 32'h120, 1'b1, 1'b0, 32'h100, "beq3");
        chk("beq3.lk_tk", 64'(bus.if_pred_taken),  64'd1);
        chk("beq3.lk_tg", 64'(bus.if_pred_target), 64'h120);
        chk("beq3.mp",    64'(bus.mispredict),     64'd0);
        commit("beq3");

        // JALR alignment and stale target
        drive(JALR, 32'h300, 32'd4, 32'h1003, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h300, "jalr1");
        chk("jalr1.tgt", 64'(bus.pc_branch), 64'h1006);
        commit("jalr1");
        drive(JALR, 32'h300, 32'd4, 32'h2000, 32'h0, 1'b1, 32'h1006, 1'b1, 1'b0, 32'h300, "jalr2");
        chk("jalr2.mp", 64'(bus.mispredict), 64'd1);
        commit("jalr2");

        // Signed/unsigned split
        drive(BLT,  32'h400, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, "blt");
        chk("blt.tk", 64'(bus.branch_taken), 64'd1);
        commit("blt");
        drive(BLTU, 32'h400, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, "bltu");
        chk("bltu.pc", 64'(bus.pc_branch), 64'h404);
        commit("bltu");
        drive(BGE,  32'h400, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, "bge");
        chk("bge.tk", 64'(bus.branch_taken), 64'd0);
        commit("bge");
        drive(BGEU, 32'h400, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, "bgeu");
        chk("bgeu.tk", 64'(bus.branch_taken), 64'd1);
        commit("bgeu");

        // Aliasing and same-cycle write/read
        drive(BNE, 32'h200, 32'h80, 32'd1, 32'd2, 1'b0, 32'h0, 1'b1, 1'b0, 32'h200, "alias");
        chk("alias.old", 64'(bus.if_pred_taken), 64'd0);
        commit("alias");
        drive(BNE, 32'h200, 32'h80, 32'd1, 32'd2, 1'b1, 32'h280, 1'b0, 1'b0, 32'h100, "alias2");
        chk("alias2.miss", 64'(bus.if_pred_taken), 64'd0);
        commit("alias2");
        drive(BNE, 32'h200, 32'h80, 32'd1, 32'd2, 1'b1, 32'h280, 1'b0, 1'b0, 32'h200, "alias3");
        chk("alias3.new", 64'(bus.if_pred_target), 64'h280);
        commit("alias3");

        // id_valid low and stall behaviour
        drive(JAL, 32'h500, 32'h40, 32'h0, 32'h0, 1'b1, 32'h540, 1'b0, 1'b0, 32'h500, "novalid");
        chk("novalid.pc", 64'(bus.pc_branch), 64'h504);
        commit("novalid");
        repeat (3) begin
            drive(JAL, 32'h600, 32'h40, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h600, "stall");
            chk("stall.mp", 64'(bus.mispredict), 64'd1);
            commit("stall");
        end
        drive(JAL, 32'h600, 32'h40, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h600, "unstall");
        commit("unstall");

        // Randomized resolves with pipeline-style predictions
        for (int n = 0; n < 300; n++) begin
            op  = 3'($urandom_range(0, 7));
            pc  = pool_pc();
            lpc = ($urandom_range(0, 1) != 0) ? pc : pool_pc();
            li  = idx_of(pc);
            if ($urandom_range(0, 1) != 0) begin
                pt  = m_valid[li] && (m_tagpc[li] == tag_of(pc)) && (m_ctr[li] >= 2);
                ptg = pt ? m_tgt[li] : 32'd0;
            end else begin
                pt  = 1'($urandom_range(0, 1));
                ptg = 32'h1000 + (32'($urandom_range(0, 15)) << 4);
            end
            drive(op, pc, 32'($urandom_range(0, 15)) << 4, pick_rs(), pick_rs(), pt, ptg,
                  ($urandom_range(0, 9) != 0), ($urandom_range(0, 4) == 0), lpc, "rnd");
            commit("rnd");
        end

        // Asynchronous reset mid-cycle
        drive(BEQ, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0, 32'h0, 1'b1, 1'b0, 32'h100, "prerst");
        rst_n = 1'b0;
        #1;
        chk("arst.perf_br", 64'(bus.perf_branches),    64'd0);
        chk("arst.perf_mp", 64'(bus.perf_mispredicts), 64'd0);
        chk("arst.pred_tk", 64'(bus.if_pred_taken),    64'd0);
        model_reset();
        bus.id_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Ten resolves, three mispredicted, two of those stalled four cycles
        for (int k = 0; k < 10; k++) begin
            pc = 32'h800 + 32'(k * 4);
            if (k == 2 || k == 5) begin
                repeat (4) begin
                    drive(JAL, pc, 32'h40, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, pc, "pstall");
                    commit("pstall");
                end
                drive(JAL, pc, 32'h40, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, pc, "pmis");
            end else if (k == 7) begin
                drive(JAL, pc, 32'h40, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, pc, "pmis");
            end else begin
                drive(JAL, pc, 32'h40, 32'h0, 32'h0, 1'b1, pc + 32'h40, 1'b1, 1'b0, pc, "pok");
            end
            commit("perf");
        end
`ifdef ELBETH_BRANCH_PERF_EN
        pexp_br = 10; pexp_mp = 3;
`else
        pexp_br = 0;  pexp_mp = 0;
`endif
        chk("perf.total_br", 64'(bus.perf_branches),    64'(pexp_br));
        chk("perf.total_mp", 64'(bus.perf_mispredicts), 64'(pexp_mp));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
